// File: rtl/timer_compare.sv
// 64-bit compare timer: compares the upstream free-running Count against a
// software-programmed compare value, raises a sticky pending flag on match,
// and optionally re-arms itself by adding a period (periodic mode).
// Register file is 8 x 32-bit words; 64-bit values are written low-then-high
// through staging registers and read coherently through a snapshot.
module timer_compare (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] Count,
    input  logic        WrEn,
    input  logic        RdEn,
    input  logic [2:0]  Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Irq
);

    localparam logic [2:0] A_CMP_LO = 3'd0;
    localparam logic [2:0] A_CMP_HI = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_CNT_LO = 3'd4;
    localparam logic [2:0] A_CNT_HI = 3'd5;
    localparam logic [2:0] A_PER_LO = 3'd6;
    localparam logic [2:0] A_PER_HI = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_FIRED = 2'b10
    } state_t;

    state_t      state_q,     state_d;
    logic [63:0] cmp_q,       cmp_d;
    logic [63:0] per_q,       per_d;
    logic [31:0] cmp_stage_q, cmp_stage_d;
    logic [31:0] per_stage_q, per_stage_d;
    logic [31:0] snap_q,      snap_d;
    logic        en_q,        en_d;
    logic        periodic_q,  periodic_d;
    logic        ie_q,        ie_d;
    logic        pending_q,   pending_d;
    logic [31:0] rd_data_q,   rd_data_d;
    logic        irq_q,       irq_d;

    logic wr_cmp_lo_s;
    logic wr_cmp_hi_s;
    logic wr_ctrl_s;
    logic wr_status_s;
    logic wr_per_lo_s;
    logic wr_per_hi_s;
    logic disable_s;
    logic match_s;
    logic fire_s;

    // Write strobes per register; a CTRL write with en=0 kills any same-edge match.
    always_comb begin
        wr_cmp_lo_s = WrEn && (Addr == A_CMP_LO);
        wr_cmp_hi_s = WrEn && (Addr == A_CMP_HI);
        wr_ctrl_s   = WrEn && (Addr == A_CTRL);
        wr_status_s = WrEn && (Addr == A_STATUS);
        wr_per_lo_s = WrEn && (Addr == A_PER_LO);
        wr_per_hi_s = WrEn && (Addr == A_PER_HI);
        disable_s   = wr_ctrl_s && !WrData[0];
        match_s     = (state_q == ST_ARMED) && (Count >= cmp_q);
        fire_s      = match_s && !disable_s;
    end

    // Next-state logic for the timer FSM, compare/period registers and flags.
    always_comb begin
        state_d     = state_q;
        cmp_d       = cmp_q;
        per_d       = per_q;
        cmp_stage_d = cmp_stage_q;
        per_stage_d = per_stage_q;
        en_d        = en_q;
        periodic_d  = periodic_q;
        ie_d        = ie_q;
        pending_d   = pending_q;

        if (wr_ctrl_s) begin
            en_d       = WrData[0];
            periodic_d = WrData[1];
            ie_d       = WrData[2];
        end else begin
            en_d = en_q;
        end

        if (wr_cmp_lo_s) begin
            cmp_stage_d = WrData;
        end else begin
            cmp_stage_d = cmp_stage_q;
        end

        if (wr_per_lo_s) begin
            per_stage_d = WrData;
        end else begin
            per_stage_d = per_stage_q;
        end

        if (wr_per_hi_s) begin
            per_d = {WrData, per_stage_q};
        end else begin
            per_d = per_q;
        end

        // Clear first so that a same-edge match below wins.
        if (wr_status_s && WrData[0]) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl_s && WrData[0]) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (fire_s) begin
                    pending_d = 1'b1;
                    if (periodic_q && (per_q != 64'd0)) begin
                        cmp_d   = cmp_q + per_q;
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_FIRED;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_FIRED: begin
                state_d = ST_FIRED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A committed compare value overrides any periodic increment and re-arms.
        if (wr_cmp_hi_s) begin
            cmp_d = {WrData, cmp_stage_q};
            if ((state_q != ST_IDLE) && en_q) begin
                state_d = ST_ARMED;
            end else begin
                state_d = state_d;
            end
        end else begin
            cmp_d = cmp_d;
        end

        if (disable_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Read mux and coherent-count snapshot; RdData holds when no read is issued.
    always_comb begin
        rd_data_d = rd_data_q;
        snap_d    = snap_q;
        if (RdEn) begin
            case (Addr)
                A_CMP_LO: rd_data_d = cmp_q[31:0];
                A_CMP_HI: rd_data_d = cmp_q[63:32];
                A_CTRL:   rd_data_d = {29'd0, ie_q, periodic_q, en_q};
                A_STATUS: rd_data_d = {28'd0, state_q, 1'b0, pending_q};
                A_CNT_LO: begin
                    rd_data_d = Count[31:0];
                    snap_d    = Count[63:32];
                end
                A_CNT_HI: rd_data_d = snap_q;
                A_PER_LO: rd_data_d = per_q[31:0];
                A_PER_HI: rd_data_d = per_q[63:32];
                default:  rd_data_d = 32'd0;
            endcase
        end else begin
            rd_data_d = rd_data_q;
        end
        irq_d = pending_d && ie_d;
    end

    // State register with synchronous reset that overrides all other activity.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cmp_q       <= 64'd0;
            per_q       <= 64'd0;
            cmp_stage_q <= 32'd0;
            per_stage_q <= 32'd0;
            snap_q      <= 32'd0;
            en_q        <= 1'b0;
            periodic_q  <= 1'b0;
            ie_q        <= 1'b0;
            pending_q   <= 1'b0;
            rd_data_q   <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_q       <= cmp_d;
            per_q       <= per_d;
            cmp_stage_q <= cmp_stage_d;
            per_stage_q <= per_stage_d;
            snap_q      <= snap_d;
            en_q        <= en_d;
            periodic_q  <= periodic_d;
            ie_q        <= ie_d;
            pending_q   <= pending_d;
            rd_data_q   <= rd_data_d;
            irq_q       <= irq_d;
        end
    end

    assign RdData = rd_data_q;
    assign Irq    = irq_q;

endmodule

// File: tb/tb_timer_compare.sv
// Directed, table-driven bench for timer_compare. Each table row is one clock
// cycle of register traffic plus a Count value, with the hand-computed Irq
// (and RdData for reads) expected just after that rising edge.
module tb_timer_compare;

    logic        Clk;
    logic        Rst;
    logic [63:0] Count;
    logic        WrEn;
    logic        RdEn;
    logic [2:0]  Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Irq;

    timer_compare dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Count  (Count),
        .WrEn   (WrEn),
        .RdEn   (RdEn),
        .Addr   (Addr),
        .WrData (WrData),
        .RdData (RdData),
        .Irq    (Irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [63:0] cnt;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[128];
    int   nv;
    int   n_applied;
    int   n_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied = n_applied + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [2:0] a, input logic [31:0] wd,
                       input logic [63:0] cnt, input logic chk, input logic [31:0] erd, input logic eirq);
        vecs[nv].we      = we;
        vecs[nv].re      = re;
        vecs[nv].addr    = a;
        vecs[nv].wd      = wd;
        vecs[nv].cnt     = cnt;
        vecs[nv].chk_rd  = chk;
        vecs[nv].exp_rd  = erd;
        vecs[nv].exp_irq = eirq;
        nv = nv + 1;
    endtask

    task automatic add_w(input logic [2:0] a, input logic [31:0] wd, input logic [63:0] cnt, input logic eirq);
        add(1'b1, 1'b0, a, wd, cnt, 1'b0, 32'd0, eirq);
    endtask

    task automatic add_r(input logic [2:0] a, input logic [63:0] cnt, input logic [31:0] erd, input logic eirq);
        add(1'b0, 1'b1, a, 32'd0, cnt, 1'b1, erd, eirq);
    endtask

    task automatic add_i(input logic [63:0] cnt, input logic eirq);
        add(1'b0, 1'b0, 3'd0, 32'd0, cnt, 1'b0, 32'd0, eirq);
    endtask

    // One cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic rst, input logic we, input logic re, input logic [2:0] a,
                         input logic [31:0] wd, input logic [63:0] cnt);
        Rst    = rst;
        WrEn   = we;
        RdEn   = re;
        Addr   = a;
        WrData = wd;
        Count  = cnt;
        @(posedge Clk);
        #1;
        WrEn = 1'b0;
        RdEn = 1'b0;
    endtask

    initial begin
        nv = 0;
        n_applied = 0;
        n_miss = 0;
        Rst = 1'b1; WrEn = 1'b0; RdEn = 1'b0; Addr = 3'd0; WrData = 32'd0; Count = 64'd0;

        // One-shot: Cmp=100, CTRL=0x5, Count ramps from 90
        add_w(3'd0, 32'd100, 64'd0, 1'b0);
        add_w(3'd1, 32'd0,   64'd0, 1'b0);
        add_r(3'd0, 64'd0, 32'd100, 1'b0);
        add_w(3'd2, 32'h5, 64'd90, 1'b0);
        add_i(64'd98, 1'b0);
        add_i(64'd99, 1'b0);
        add_i(64'd100, 1'b1);
        add_r(3'd3, 64'd101, 32'h9, 1'b1);
        add_w(3'd3, 32'h1, 64'd102, 1'b0);
        add_r(3'd3, 64'd103, 32'h8, 1'b0);
        add_r(3'd2, 64'd104, 32'h5, 1'b0);
        // Periodic: Cmp=100, Per=50, CTRL=0x7
        add_w(3'd2, 32'h0, 64'd0, 1'b0);
        add_w(3'd0, 32'd100, 64'd0, 1'b0);
        add_w(3'd1, 32'd0, 64'd0, 1'b0);
        add_w(3'd6, 32'd50, 64'd0, 1'b0);
        add_w(3'd7, 32'd0, 64'd0, 1'b0);
        add_w(3'd2, 32'h7, 64'd0, 1'b0);
        add_i(64'd99, 1'b0);
        add_i(64'd100, 1'b1);
        add_w(3'd3, 32'h1, 64'd101, 1'b0);
        add_i(64'd149, 1'b0);
        add_i(64'd150, 1'b1);
        add_w(3'd3, 32'h1, 64'd151, 1'b0);
        add_i(64'd200, 1'b1);
        add_w(3'd3, 32'h1, 64'd201, 1'b0);
        add_r(3'd0, 64'd202, 32'd250, 1'b0);
        add_r(3'd1, 64'd203, 32'd0, 1'b0);
        add_r(3'd6, 64'd204, 32'd50, 1'b0);
        add_r(3'd3, 64'd205, 32'h4, 1'b0);
        // Wrap: Cmp=0xFFFF_FFFF_FFFF_FFF0, Per=0x20
        add_w(3'd2, 32'h0, 64'd0, 1'b0);
        add_w(3'd0, 32'hFFFF_FFF0, 64'd0, 1'b0);
        add_w(3'd1, 32'hFFFF_FFFF, 64'd0, 1'b0);
        add_w(3'd6, 32'h20, 64'd0, 1'b0);
        add_w(3'd7, 32'h0, 64'd0, 1'b0);
        add_w(3'd2, 32'h7, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
        add_i(64'hFFFF_FFFF_FFFF_FFEF, 1'b0);
        add_i(64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
        add_r(3'd0, 64'h3, 32'h10, 1'b1);
        add_r(3'd1, 64'h4, 32'h0, 1'b1);
        add_w(3'd3, 32'h1, 64'h5, 1'b0);
        add_i(64'hF, 1'b0);
        add_i(64'h10, 1'b1);
        // Coherent count read, and ignored writes to CNT registers
        add_w(3'd2, 32'h0, 64'h11, 1'b0);
        add_w(3'd3, 32'h1, 64'h11, 1'b0);
        add_r(3'd4, 64'h0000_0001_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add_i(64'h0000_0002_0000_0005, 1'b0);
        add_r(3'd5, 64'h0000_0002_0000_0006, 32'h0000_0001, 1'b0);
        add_w(3'd4, 32'hDEAD_BEEF, 64'd0, 1'b0);
        add_w(3'd5, 32'hDEAD_BEEF, 64'd0, 1'b0);
        add_r(3'd5, 64'd0, 32'h0000_0001, 1'b0);
        add_r(3'd2, 64'd0, 32'h0, 1'b0);
        // Same-cycle STATUS clear + match, then same-cycle en=0 + match
        add_w(3'd0, 32'h50, 64'd0, 1'b0);
        add_w(3'd1, 32'h0, 64'd0, 1'b0);
        add_w(3'd2, 32'h7, 64'h10, 1'b0);
        add_i(64'h50, 1'b1);
        add_w(3'd3, 32'h1, 64'h70, 1'b1);
        add_r(3'd3, 64'h71, 32'h5, 1'b1);
        add_w(3'd3, 32'h1, 64'h72, 1'b0);
        add_w(3'd2, 32'h4, 64'h90, 1'b0);
        add_r(3'd3, 64'h91, 32'h0, 1'b0);
        add_r(3'd2, 64'h92, 32'h4, 1'b0);
        // CMP_HI commit with simultaneous match; FIRED re-armed by commit
        add_w(3'd0, 32'h100, 64'd0, 1'b0);
        add_w(3'd1, 32'h0, 64'd0, 1'b0);
        add_w(3'd2, 32'h5, 64'd0, 1'b0);
        add_w(3'd0, 32'h300, 64'h50, 1'b0);
        add_w(3'd1, 32'h0, 64'h100, 1'b1);
        add_r(3'd3, 64'h101, 32'h5, 1'b1);
        add_r(3'd0, 64'h102, 32'h300, 1'b1);
        add_w(3'd3, 32'h1, 64'h301, 1'b1);
        add_r(3'd3, 64'h302, 32'h9, 1'b1);
        add_w(3'd3, 32'h1, 64'h303, 1'b0);
        add_w(3'd0, 32'h400, 64'h303, 1'b0);
        add_w(3'd1, 32'h0, 64'h303, 1'b0);
        add_r(3'd3, 64'h304, 32'h4, 1'b0);

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
        Rst = 1'b0;
        check("reset RdData", RdData, 32'd0);
        check("reset Irq", {31'd0, Irq}, 32'd0);

        for (int i = 0; i < nv; i++) begin
            drive(1'b0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd, vecs[i].cnt);
            check($sformatf("vec%0d irq", i), {31'd0, Irq}, {31'd0, vecs[i].exp_irq});
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d rd", i), RdData, vecs[i].exp_rd);
            end
        end

        // Reset while FIRED with pending=1, staged CMP_LO, and a colliding write
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 64'h400);
        check("pre-reset irq", {31'd0, Irq}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'h55, 64'h401);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h7, 64'h401);
        check("mid reset irq", {31'd0, Irq}, 32'd0);
        check("mid reset rd", RdData, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h0, 64'h401);
        check("post reset irq", {31'd0, Irq}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 64'h402);
        check("staging discarded", RdData, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd3, 32'd0, 64'h403);
        check("post reset status", RdData, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd2, 32'd0, 64'h404);
        check("post reset ctrl", RdData, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd6, 32'd0, 64'h405);
        check("post reset per", RdData, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/timer_compare.md
TIMER_COMPARE -- requirements
Module: timer_compare

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Rst  input  1  reset, synchronous, active-high.
REQ-003 Count  input  64  free-running cycle count from the upstream 64-bit counter; unsigned.
REQ-004 WrEn  input  1  register write strobe, one cycle per write.
REQ-005 RdEn  input  1  register read strobe, one cycle per read.
REQ-006 Addr  input  3  register select; 0 CMP_LO, 1 CMP_HI, 2 CTRL, 3 STATUS, 4 CNT_LO, 5 CNT_HI, 6 PER_LO, 7 PER_HI.
REQ-007 WrData  input  32  write data.
REQ-008 RdData  output  32  read data, registered.
REQ-009 Irq  output  1  interrupt request, level, = STATUS.pending AND CTRL.ie.

Function
REQ-010 CTRL bit0 en, bit1 periodic, bit2 ie; bits 31:3 read 0, writes ignored.
REQ-011 STATUS bit0 pending; write with WrData[0]=1 clears pending; bits 31:1 read 0.
REQ-012 CMP_LO write loads 32-bit staging register only; CMP_HI write commits {WrData, staging} to 64-bit Cmp in the same edge.
REQ-013 PER_LO write loads period staging; PER_HI write commits {WrData, staging} to 64-bit Per.
REQ-014 CNT_LO read returns Count[31:0] and latches Count[63:32] into snapshot in the same edge; CNT_HI read returns snapshot (coherent 64-bit read).
REQ-015 RdData valid exactly one cycle after RdEn; holds last value otherwise; CMP_LO/CMP_HI/PER_LO/PER_HI reads return committed Cmp/Per halves.
REQ-016 FSM states IDLE, ARMED, FIRED; state readable as STATUS[3:2] (00 IDLE, 01 ARMED, 10 FIRED).
REQ-017 Any state -> IDLE on the edge CTRL.en is written 0.
REQ-018 IDLE -> ARMED on the edge CTRL.en is written 1.
REQ-019 ARMED match condition: Count >= Cmp, unsigned 64-bit compare (no missed match if Cmp is already passed).
REQ-020 ARMED on match, one-shot or Per==0: pending <= 1, state -> FIRED.
REQ-021 ARMED on match, periodic and Per!=0: pending <= 1, Cmp <= Cmp + Per modulo 2^64, stay ARMED.
REQ-022 Periodic Cmp wrap past 2^64 is not special-cased; the next match occurs by the >= rule.
REQ-023 FIRED -> ARMED on a CMP_HI commit while en=1; otherwise FIRED holds, no further pending sets.
REQ-024 Match evaluated on the Count value sampled at the edge; pending and Irq assert on the following cycle (1-cycle latency).
REQ-025 Simultaneous STATUS clear and new match: pending ends 1 (set wins).
REQ-026 Simultaneous CMP_HI commit and match: match uses old Cmp, new Cmp overwrites any periodic increment, state ends ARMED.
REQ-027 Simultaneous CTRL write en=0 and match: state IDLE, pending not set.
REQ-028 Writes to read-only CNT_LO/CNT_HI ignored; reads on a write-only cycle have no side effect.

Reset
REQ-029 On Rst: state IDLE, Cmp, Per, both staging registers, snapshot, CTRL, pending, RdData all 0; Irq 0.
REQ-030 Rst overrides any simultaneous WrEn/RdEn or match; in-progress staged halves are discarded.

Verification
REQ-031 Reset mid-ARMED with pending=1 -> next cycle Irq=0, STATUS=0, CTRL=0.
REQ-032 One-shot: Cmp=100, CTRL=0x5, Count ramps from 90 -> Irq rises one cycle after Count=100, STATUS[3:2]=10, clears after STATUS write 1.
REQ-033 Periodic: Cmp=100, Per=50, CTRL=0x7, pending cleared after each fire -> pending sets at Count 100, 150, 200; CMP readback 250 after third fire.
REQ-034 Wrap: Cmp=0xFFFF_FFFF_FFFF_FFF0, Per=0x20, periodic -> after fire Cmp=0x10, next fire at Count>=0x10 after upstream counter wraps.
REQ-035 Coherent read: Count=0x0000_0001_FFFF_FFFF at CNT_LO read -> RdData=0xFFFF_FFFF, then CNT_HI read two cycles later -> 0x0000_0001.
REQ-036 Same-cycle STATUS clear and match -> pending remains 1; same-cycle en=0 and match -> IDLE, pending 0.
